uart_ram_arbiter: RTL and testbench

- Parametrised N-port arbiter that shares one simple dual-port RAM (one sync read port, one write port) among NUM_PORTS requesters, e.g. UART RX/TX engines and the CPU bus.
- Read and write sides are arbitrated independently. Each side uses fixed-priority or round-robin selection.
- Each port writes only into its own region (region index = port index) and may read any region, giving N-way mailbox queues.

---
 rtl/uart_ram_arbiter_pkg.sv | 19 +
 rtl/uart_ram_arbiter_if.sv | 14 +
 rtl/uart_ram_arbiter_rr_arbiter.sv | 60 ++++++
 rtl/uart_ram_arbiter.sv | 87 ++++++++
 tb/tb_uart_ram_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ram_arbiter_pkg.sv
// Shared arbitration-mode encodings and helpers for the RAM arbiter.
package uart_ram_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Encodes an up-to-8-bit one-hot vector as its bit index; zero maps to 0.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_ram_arbiter_if.sv
// Simple dual-port RAM bus: one synchronous read port, one write port.
interface uart_ram_if #(
    parameter int AW = 9,
    parameter int DW = 8
) ();
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          we;

    modport master (output r_addr, output w_addr, output w_data, output we, input r_data);
    modport slave  (input r_addr, input w_addr, input w_data, input we, output r_data);
endinterface

// File: rtl/uart_ram_arbiter_rr_arbiter.sv
// Single-side request arbiter: fixed priority or round robin with a
// last-granted pointer that only moves when a grant is actually taken.
module rr_arbiter
    import uart_ram_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int RR_MODE   = ARB_RR,
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_advance,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [PORT_W-1:0]    o_grant_idx
);

    logic [PORT_W-1:0] ptr_q;
    logic [PORT_W-1:0] ptr_d;
    logic              found;

    always_comb begin
        o_grant = '0;
        found   = 1'b0;
        if (RR_MODE == ARB_RR) begin
            // Search starts just after the last winner so it becomes lowest priority.
            for (int k = 1; k <= NUM_PORTS; k++) begin
                if (!found && i_req[PORT_W'((int'(ptr_q) + k) % NUM_PORTS)]) begin
                    o_grant[PORT_W'((int'(ptr_q) + k) % NUM_PORTS)] = 1'b1;
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found && i_req[PORT_W'(k)]) begin
                    o_grant[PORT_W'(k)] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end

    assign o_grant_idx = PORT_W'(onehot_to_idx(8'(o_grant)));

    always_comb begin
        ptr_d = ptr_q;
        if (RR_MODE == ARB_RR && i_advance && (|i_req)) begin
            ptr_d = o_grant_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= PORT_W'(NUM_PORTS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_ram_arbiter.sv
// Shares one simple dual-port RAM among NUM_PORTS requesters; each port
// writes only its own region (upper address bits = port index) and reads any.
module uart_ram_arbiter
    import uart_ram_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int ADDR_W    = 8,
    parameter  int DATA_W    = 8,
    parameter  int RR_MODE   = ARB_RR,
    localparam int PORT_W    = $clog2(NUM_PORTS),
    localparam int FA_W      = PORT_W + ADDR_W
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    uart_ram_if.master                  ram,
    input  logic [NUM_PORTS-1:0]        i_re,
    input  logic [NUM_PORTS*FA_W-1:0]   i_r_addr,
    output logic [DATA_W-1:0]           o_r_data,
    output logic [NUM_PORTS-1:0]        o_r_ack,
    input  logic [NUM_PORTS-1:0]        i_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] i_w_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] i_w_data,
    output logic [NUM_PORTS-1:0]        o_w_ack
);

    logic [FA_W-1:0]      r_addr_a [NUM_PORTS];
    logic [ADDR_W-1:0]    w_addr_a [NUM_PORTS];
    logic [DATA_W-1:0]    w_data_a [NUM_PORTS];

    logic [NUM_PORTS-1:0] r_grant;
    logic [PORT_W-1:0]    r_idx;
    logic [NUM_PORTS-1:0] w_grant;
    logic [PORT_W-1:0]    w_idx;
    logic [NUM_PORTS-1:0] r_ack_q;
    logic [NUM_PORTS-1:0] r_ack_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign r_addr_a[gi] = i_r_addr[gi*FA_W   +: FA_W];
            assign w_addr_a[gi] = i_w_addr[gi*ADDR_W +: ADDR_W];
            assign w_data_a[gi] = i_w_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .RR_MODE(RR_MODE)) u_rd_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_re),
        .i_advance   (|i_re),
        .o_grant     (r_grant),
        .o_grant_idx (r_idx)
    );

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .RR_MODE(RR_MODE)) u_wr_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_we),
        .i_advance   (|i_we),
        .o_grant     (w_grant),
        .o_grant_idx (w_idx)
    );

    // Read side: address goes straight to the RAM; the ack lines up with its data.
    assign ram.r_addr = r_addr_a[r_idx];
    assign o_r_data   = ram.r_data;
    assign o_r_ack    = r_ack_q;

    always_comb begin
        r_ack_d = r_grant & {NUM_PORTS{|i_re}};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_q <= '0;
        end else begin
            r_ack_q <= r_ack_d;
        end
    end

    // Write side is fully combinational; the commit happens on the RAM's edge.
    assign o_w_ack    = i_rst ? '0 : w_grant;
    assign ram.we     = (|i_we) & ~i_rst;
    assign ram.w_addr = {w_idx, w_addr_a[w_idx]};
    assign ram.w_data = w_data_a[w_idx];

endmodule

// File: tb/tb_uart_ram_arbiter.sv
// Directed + randomized checks of the RAM arbiter against a queue-free
// behavioural model of priority search order and RAM contents.
module tb_uart_ram_arbiter;
    import uart_ram_arb_pkg::*;

    localparam int NP = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int FA = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NP-1:0]    re, we, fx_re, fx_we;
    logic [NP*FA-1:0] r_addr_f;
    logic [NP*AW-1:0] w_addr_f;
    logic [NP*DW-1:0] w_data_f;

    logic [DW-1:0] rr_rdata, fx_rdata;
    logic [NP-1:0] rr_rack, rr_wack, fx_rack, fx_wack;

    uart_ram_if #(.AW(FA), .DW(DW)) rif ();
    uart_ram_if #(.AW(FA), .DW(DW)) fif ();

    uart_ram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(ARB_RR)) dut_rr (
        .i_clk(clk), .i_rst(rst), .ram(rif),
        .i_re(re), .i_r_addr(r_addr_f), .o_r_data(rr_rdata), .o_r_ack(rr_rack),
        .i_we(we), .i_w_addr(w_addr_f), .i_w_data(w_data_f), .o_w_ack(rr_wack)
    );

    uart_ram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(ARB_FIXED)) dut_fx (
        .i_clk(clk), .i_rst(rst), .ram(fif),
        .i_re(fx_re), .i_r_addr(r_addr_f), .o_r_data(fx_rdata), .o_r_ack(fx_rack),
        .i_we(fx_we), .i_w_addr(w_addr_f), .i_w_data(w_data_f), .o_w_ack(fx_wack)
    );

    // RAM behind the round-robin instance: synchronous read-before-write.
    logic [DW-1:0] mem_rr [1 << FA];
    always @(posedge clk) begin
        if (rif.we) mem_rr[rif.w_addr] <= rif.w_data;
        rif.r_data <= mem_rr[rif.r_addr];
    end
    assign fif.r_data = 8'h00;

    // Reference model state
    int            n_cmp = 0;
    int            n_bad = 0;
    int            wptr, rptr;
    logic [DW-1:0] mem_m [1 << FA];
    bit            known [1 << FA];
    logic [NP-1:0] exp_rack;
    logic [DW-1:0] exp_rdata;
    bit            exp_rknown;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FA-1:0] ra(input int p);
        return r_addr_f[p*FA +: FA];
    endfunction
    function automatic logic [AW-1:0] wa(input int p);
        return w_addr_f[p*AW +: AW];
    endfunction
    function automatic logic [DW-1:0] wd(input int p);
        return w_data_f[p*DW +: DW];
    endfunction

    task automatic set_r(input int p, input logic [FA-1:0] a);
        r_addr_f[p*FA +: FA] = a;
    endtask
    task automatic set_w(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        w_addr_f[p*AW +: AW] = a;
        w_data_f[p*DW +: DW] = d;
    endtask

    // One clock of the round-robin instance: check against the model, then advance.
    task automatic cyc();
        int wg, rg, p;
        int a;
        #3;
        wg = -1;
        rg = -1;
        if (!rst) begin
            for (int k = 1; k <= NP; k++) begin
                p = (wptr + k) % NP;
                if (wg < 0 && we[p]) wg = p;
            end
        end
        for (int k = 1; k <= NP; k++) begin
            p = (rptr + k) % NP;
            if (rg < 0 && re[p]) rg = p;
        end
        check("w_ack", 32'(rr_wack), (wg < 0) ? 32'd0 : (32'd1 << wg));
        check("ram_we", 32'(rif.we), (wg >= 0) ? 32'd1 : 32'd0);
        if (wg >= 0) begin
            check("ram_w_addr", 32'(rif.w_addr), 32'(wg * 256 + int'(wa(wg))));
            check("ram_w_data", 32'(rif.w_data), 32'(wd(wg)));
        end
        check("r_ack", 32'(rr_rack), 32'(exp_rack));
        if (exp_rack != 0 && exp_rknown) check("r_data", 32'(rr_rdata), 32'(exp_rdata));
        if (rg >= 0 && !rst) check("ram_r_addr", 32'(rif.r_addr), 32'(ra(rg)));

        if (rst) begin
            exp_rack = '0;
            wptr = NP - 1;
            rptr = NP - 1;
        end else begin
            exp_rack = (rg < 0) ? '0 : NP'(1 << rg);
            if (rg >= 0) begin
                a = int'(ra(rg));
                exp_rdata  = mem_m[a];
                exp_rknown = known[a];
                rptr = rg;
            end
            if (wg >= 0) begin
                a = wg * 256 + int'(wa(wg));
                mem_m[a] = wd(wg);
                known[a] = 1'b1;
                wptr = wg;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << FA); i++) known[i] = 1'b0;
        rst = 1'b1;
        re = '0; we = '0; fx_re = '0; fx_we = '0;
        r_addr_f = '0; w_addr_f = '0; w_data_f = '0;
        wptr = NP - 1; rptr = NP - 1;
        exp_rack = '0; exp_rdata = '0; exp_rknown = 1'b0;

        // Reset
        cyc();
        cyc();
        check("reset_rr_r_ack", 32'(rr_rack), 32'd0);
        check("reset_fx_r_ack", 32'(fx_rack), 32'd0);

        // All four ports write local 0x10 after release: grants rotate 0,1,2,3,0
        rst = 1'b0;
        we = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            for (int p = 0; p < NP; p++) set_w(p, 8'h10, 8'($urandom));
            #3;
            check("rot_w_ack", 32'(rr_wack), 32'd1 << (i % NP));
            check("rot_w_addr", 32'(rif.w_addr), 32'((i % NP) * 256 + 16));
            #(-0);
            cyc();
        end
        we = '0;

        // Port 1 writes 0xA5 at local 0x03; port 0 reads full address 0x103
        we = 4'b0010;
        set_w(1, 8'h03, 8'hA5);
        cyc();
        we = '0;
        re = 4'b0001;
        set_r(0, 10'h103);
        cyc();
        check("mbox_ack", 32'(rr_rack), 32'd1);
        check("mbox_data", 32'(rr_rdata), 32'hA5);
        re = '0;
        cyc();

        // Port 3 requests one cycle then drops while port 1 requests
        re = 4'b1000;
        set_r(3, 10'h103);
        cyc();
        re = 4'b0010;
        set_r(1, 10'h110);
        check("drop_ack3", 32'(rr_rack), 32'h8);
        cyc();
        re = '0;
        check("drop_ack1", 32'(rr_rack), 32'h2);
        cyc();
        check("drop_none", 32'(rr_rack), 32'h0);

        // Reset mid-operation with port 2 writing and port 1 reading
        we = 4'b0100;
        set_w(2, 8'h20, 8'h5C);
        re = 4'b0010;
        cyc();
        rst = 1'b1;
        #3;
        check("rst_w_ack", 32'(rr_wack), 32'd0);
        check("rst_we", 32'(rif.we), 32'd0);
        cyc();
        check("rst_r_ack", 32'(rr_rack), 32'd0);
        rst = 1'b0;
        we = '0;
        re = 4'b0110;
        set_r(2, 10'h020);
        cyc();
        check("rst_ptr_port1", 32'(rr_rack), 32'h2);
        re = 4'b0100;
        cyc();
        check("rst_then_port2", 32'(rr_rack), 32'h4);
        re = '0;
        cyc();

        // Same-cycle read and write of RAM word 0x005
        we = 4'b0001;
        set_w(0, 8'h05, 8'h11);
        cyc();
        set_w(0, 8'h05, 8'h22);
        re = 4'b0001;
        set_r(0, 10'h005);
        cyc();
        check("rbw_old", 32'(rr_rdata), 32'h11);
        we = '0;
        cyc();
        check("rbw_new", 32'(rr_rdata), 32'h22);
        re = '0;
        cyc();

        // Fixed priority instance: ports 0 and 2 hold read requests
        fx_re = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("fx_port0", 32'(fx_rack), 32'h1);
        end
        fx_re = 4'b0100;
        #3;
        check("fx_drop_prev", 32'(fx_rack), 32'h1);
        cyc();
        check("fx_port2", 32'(fx_rack), 32'h4);
        fx_re = '0;
        fx_we = 4'b1110;
        #3;
        check("fx_w_low", 32'(fx_wack), 32'h2);
        fx_we = 4'b1111;
        #1;
        check("fx_w_port0", 32'(fx_wack), 32'h1);
        cyc();
        fx_we = '0;
        cyc();
        check("fx_idle", 32'(fx_rack), 32'h0);

        // Randomized traffic on the round-robin instance
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            we = 4'($urandom);
            re = 4'($urandom);
            for (int p = 0; p < NP; p++) begin
                set_w(p, 8'($urandom_range(0, 7)), 8'($urandom));
                set_r(p, {2'($urandom), 8'($urandom_range(0, 7))});
            end
            cyc();
        end
        rst = 1'b0;
        we = '0;
        re = '0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
